// File: rtl/hamming_reg_ctrl.sv
// Transfer controller for the Hamming-protected shift register.
// It accepts a parallel word, loads the register in PISO mode and streams the
// word out LSB-first. While streaming, any fault reported by the register
// turns the cycle into a correction stall. Two back-to-back faulty stalls
// mean the error was not correctable, so the transfer is aborted.
module hamming_reg_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_bit,
  output logic             ser_last,
  output logic             done,
  output logic             reg_enable,
  output logic             reg_load,
  output logic [1:0]       reg_mode,
  output logic [WIDTH-1:0] reg_parallel_in,
  input  logic             reg_serial_out,
  input  logic             reg_fault,
  input  logic             clr_err,
  output logic [CNT_W-1:0] err_count,
  output logic             uncorr
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] word_q;
  logic             fix_pending_q;
  logic             corr_cyc;
  logic             uncorr_cyc;
  logic             done_d;

  // Correction counter saturates instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign reg_mode        = 2'b10;
  assign reg_parallel_in = word_q;

  // Next-state, handshake and register-control decode.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    in_ready   = 1'b0;
    ser_valid  = 1'b0;
    ser_bit    = 1'b0;
    ser_last   = 1'b0;
    reg_enable = 1'b0;
    reg_load   = 1'b0;
    corr_cyc   = 1'b0;
    uncorr_cyc = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        // The register is idle-stalled, so it self-corrects here as well.
        if (reg_fault) begin
          if (fix_pending_q) uncorr_cyc = 1'b1;
          else               corr_cyc   = 1'b1;
        end
        if (in_valid) state_d = S_LOAD;
      end
      S_LOAD: begin
        reg_enable = 1'b1;
        reg_load   = 1'b1;
        bit_cnt_d  = '0;
        state_d    = S_SHIFT;
      end
      S_SHIFT: begin
        if (reg_fault) begin
          // Stall so the register can fix itself; a repeat fault means it could not.
          if (fix_pending_q) begin
            uncorr_cyc = 1'b1;
            state_d    = S_IDLE;
          end else begin
            corr_cyc = 1'b1;
          end
        end else begin
          ser_valid  = 1'b1;
          ser_bit    = reg_serial_out;
          ser_last   = (bit_cnt_q == LAST_IDX);
          reg_enable = ser_ready;
          if (ser_ready) begin
            if (bit_cnt_q == LAST_IDX) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, bit counter, captured word and correction tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      word_q        <= '0;
      fix_pending_q <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      fix_pending_q <= corr_cyc;
      done          <= done_d;
      if (state_q == S_IDLE && in_valid) word_q <= in_data;
    end
  end

  // Error statistics; a clear request overrides any same-cycle update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
      uncorr    <= 1'b0;
    end else if (clr_err) begin
      err_count <= '0;
      uncorr    <= 1'b0;
    end else begin
      if (corr_cyc)   err_count <= sat_inc(err_count);
      if (uncorr_cyc) uncorr    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_reg_ctrl.sv
// Directed bench for hamming_reg_ctrl with a behavioural PISO register.
module tb_hamming_reg_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_bit;
  logic             ser_last;
  logic             done;
  logic             reg_enable;
  logic             reg_load;
  logic [1:0]       reg_mode;
  logic [WIDTH-1:0] reg_parallel_in;
  logic             reg_serial_out;
  logic             reg_fault;
  logic             clr_err;
  logic [CNT_W-1:0] err_count;
  logic             uncorr;

  int total = 0;
  int bad   = 0;

  hamming_reg_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ser_valid(ser_valid), .ser_ready(ser_ready), .ser_bit(ser_bit),
    .ser_last(ser_last), .done(done),
    .reg_enable(reg_enable), .reg_load(reg_load), .reg_mode(reg_mode),
    .reg_parallel_in(reg_parallel_in), .reg_serial_out(reg_serial_out),
    .reg_fault(reg_fault), .clr_err(clr_err),
    .err_count(err_count), .uncorr(uncorr)
  );

  always #5 clk = ~clk;

  // Behavioural PISO register: load or shift right when enabled.
  logic [WIDTH-1:0] sreg = '0;
  always @(posedge clk) begin
    if (reg_enable) begin
      if (reg_load) sreg <= reg_parallel_in;
      else          sreg <= {1'b0, sreg[WIDTH-1:1]};
    end
  end
  assign reg_serial_out = sreg[0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Clean transfer starting in the current cycle (cycle 0).
  task automatic send_word(input logic [WIDTH-1:0] w, input string tag);
    in_valid = 1'b1; in_data = w; ser_ready = 1'b1; #2;
    check({tag, "_rdy0"}, in_ready, 1);
    tick(); in_valid = 1'b0; #2;
    check({tag, "_load"}, reg_load, 1);
    check({tag, "_load_en"}, reg_enable, 1);
    check({tag, "_pin"}, reg_parallel_in, w);
    check({tag, "_rdy1"}, in_ready, 0);
    for (int i = 0; i < WIDTH; i++) begin
      tick(); #2;
      check({tag, "_sv"}, ser_valid, 1);
      check({tag, "_bit"}, ser_bit, w[i]);
      check({tag, "_last"}, ser_last, (i == WIDTH - 1));
      check({tag, "_nodone"}, done, 0);
    end
    tick(); #2;
    check({tag, "_done"}, done, 1);
    check({tag, "_rdy_end"}, in_ready, 1);
    check({tag, "_sv_end"}, ser_valid, 0);
    tick(); #2;
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; ser_ready = 1'b1;
    reg_fault = 1'b0; clr_err = 1'b0;
    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_ser_valid", ser_valid, 0);
    check("rst_ser_last", ser_last, 0);
    check("rst_ser_bit", ser_bit, 0);
    check("rst_done", done, 0);
    check("rst_reg_en", reg_enable, 0);
    check("rst_reg_load", reg_load, 0);
    check("rst_reg_mode", reg_mode, 2'b10);
    check("rst_err", err_count, 0);
    check("rst_uncorr", uncorr, 0);
    check("rst_pin", reg_parallel_in, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Nominal transfer of 1011
    send_word(4'b1011, "nom");
    check("nom_err", err_count, 0);

    // Backpressure on bit 1 for three cycles
    tick(); in_valid = 1'b1; in_data = 4'b1011; #2;
    tick(); in_valid = 1'b0; #2;
    tick(); #2;
    check("bp_bit0", ser_bit, 1);
    for (int k = 0; k < 3; k++) begin
      tick(); ser_ready = 1'b0; #2;
      check("bp_hold_sv", ser_valid, 1);
      check("bp_hold_bit", ser_bit, 1);
      check("bp_hold_en", reg_enable, 0);
    end
    tick(); ser_ready = 1'b1; #2;
    check("bp_bit1", ser_bit, 1);
    check("bp_bit1_en", reg_enable, 1);
    tick(); #2;
    check("bp_bit2", ser_bit, 0);
    tick(); #2;
    check("bp_bit3", ser_bit, 1);
    check("bp_last", ser_last, 1);
    check("bp_nodone8", done, 0);
    tick(); #2;
    check("bp_done9", done, 1);

    // Single correction before bit 2 of 0110
    tick(); in_valid = 1'b1; in_data = 4'b0110; #2;
    tick(); in_valid = 1'b0; #2;
    tick(); #2;
    check("sc_bit0", ser_bit, 0);
    tick(); #2;
    check("sc_bit1", ser_bit, 1);
    tick(); reg_fault = 1'b1; #2;
    check("sc_stall_sv", ser_valid, 0);
    check("sc_stall_en", reg_enable, 0);
    tick(); reg_fault = 1'b0; #2;
    check("sc_bit2_sv", ser_valid, 1);
    check("sc_bit2", ser_bit, 1);
    check("sc_err", err_count, 1);
    tick(); #2;
    check("sc_bit3", ser_bit, 0);
    check("sc_last", ser_last, 1);
    tick(); #2;
    check("sc_done", done, 1);
    check("sc_uncorr", uncorr, 0);
    tick(); clr_err = 1'b1; #2;
    tick(); clr_err = 1'b0; #2;
    check("sc_clr", err_count, 0);

    // Uncorrectable: two consecutive faults in SHIFT
    tick(); in_valid = 1'b1; in_data = 4'b1011; #2;
    tick(); in_valid = 1'b0; #2;
    tick(); #2;
    check("uc_bit0", ser_bit, 1);
    tick(); reg_fault = 1'b1; #2;
    check("uc_f1_sv", ser_valid, 0);
    tick(); #2;
    check("uc_f2_sv", ser_valid, 0);
    check("uc_f2_en", reg_enable, 0);
    check("uc_f2_err", err_count, 1);
    tick(); reg_fault = 1'b0; #2;
    check("uc_idle", in_ready, 1);
    check("uc_flag", uncorr, 1);
    check("uc_err", err_count, 1);
    check("uc_nodone", done, 0);
    check("uc_sv", ser_valid, 0);
    tick(); #2;
    check("uc_nodone2", done, 0);
    tick(); clr_err = 1'b1; #2;
    tick(); clr_err = 1'b0; #2;
    check("uc_clr_err", err_count, 0);
    check("uc_clr_flag", uncorr, 0);

    // Saturation with isolated IDLE faults, then clear priority
    for (int k = 1; k <= 4; k++) begin
      tick(); reg_fault = 1'b1; #2;
      tick(); reg_fault = 1'b0; #2;
      check("sat_err", err_count, (k > 3) ? 3 : k);
      check("sat_uncorr", uncorr, 0);
    end
    tick(); reg_fault = 1'b1; clr_err = 1'b1; #2;
    tick(); reg_fault = 1'b0; clr_err = 1'b0; #2;
    check("sat_clr", err_count, 0);

    // Reset asserted while bit 2 is presented
    tick(); in_valid = 1'b1; in_data = 4'b1011; #2;
    tick(); in_valid = 1'b0; #2;
    tick(); #2;
    tick(); reg_fault = 1'b1; #2;
    tick(); reg_fault = 1'b0; #2;
    check("mr_err", err_count, 1);
    tick(); #2;
    check("mr_bit2_sv", ser_valid, 1);
    check("mr_bit2", ser_bit, 0);
    #1 rst = 1'b1;
    #1;
    check("mr_in_ready", in_ready, 1);
    check("mr_sv", ser_valid, 0);
    check("mr_en", reg_enable, 0);
    check("mr_load", reg_load, 0);
    check("mr_last", ser_last, 0);
    check("mr_err0", err_count, 0);
    check("mr_done", done, 0);
    check("mr_uncorr", uncorr, 0);
    tick(); rst = 1'b0;
    send_word(4'b0110, "post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hamming_reg_ctrl.md
# hamming_reg_ctrl

Transfer controller for the Hamming-protected shift register. It accepts parallel words over a valid/ready handshake and loads them into the register in PISO mode. It then streams the word out LSB-first over a serial valid/ready interface. Whenever the register reports a fault, the controller inserts correction stall cycles and counts them. It flags uncorrectable errors and aborts the transfer.

## Interface
- WIDTH, 4, register width in bits; must be a multiple of 4 and at least 4
- CNT_W, 8, width of the correction counter
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  parallel word offered
- in_ready  out  1  controller can accept a word
- in_data  in  WIDTH  word to transmit
- ser_valid  out  1  ser_bit is valid this cycle
- ser_ready  in  1  downstream accepts ser_bit
- ser_bit  out  1  serial data, LSB first
- ser_last  out  1  qualifies the final bit of a word
- done  out  1  one-cycle pulse after a word completes
- reg_enable  out  1  register enable
- reg_load  out  1  register parallel load
- reg_mode  out  2  register mode; held at 2'b10 (PISO)
- reg_parallel_in  out  WIDTH  register parallel data
- reg_serial_out  in  1  register serial output (raw reg_data[0])
- reg_fault  in  1  register syndrome non-zero
- clr_err  in  1  synchronous clear of err_count and uncorr
- err_count  out  CNT_W  corrections applied, saturating
- uncorr  out  1  sticky uncorrectable-error flag

## Operation
- **States:** IDLE, LOAD, SHIFT.
- **Stall cycle definition:** any cycle with reg_enable=0. The register self-corrects on any stall cycle where reg_fault=1.
- **IDLE**
  - in_ready=1; reg_enable=0.
  - On in_valid, capture in_data into word_q, then go to LOAD.
- **LOAD**
  - in_ready=0.
  - reg_enable=1, reg_load=1, reg_parallel_in=word_q.
  - bit_cnt is set to 0; go to SHIFT.
- **SHIFT, priority order:**
  - reg_fault=1: this is a correction cycle. ser_valid=0, reg_enable=0, and err_count increments.
  - Otherwise: ser_valid=1, ser_bit=reg_serial_out, ser_last=(bit_cnt==WIDTH-1), reg_enable=ser_ready.
- **Bit transfer:** happens when ser_valid and ser_ready are both high.
  - If bit_cnt<WIDTH-1, increment bit_cnt.
  - Otherwise go to IDLE and set done for the next cycle.
- **Uncorrectable error:** reg_fault=1 on a stall cycle that immediately follows a correction cycle.
  - Set uncorr.
  - If in SHIFT, abort to IDLE with no done.
  - Tracked by a one-bit fix_pending flag. It is set on each correction cycle and cleared on any cycle without one.
- **Correction counting in IDLE:** also counted. Persistent fault in IDLE sets uncorr; the controller stays in IDLE.
- **Counters:**
  - err_count saturates at 2^CNT_W-1.
  - clr_err wins over a simultaneous increment or uncorr set.
- **reg_parallel_in:** drives word_q in every state; only LOAD asserts reg_load.

## Timing
- **Reset values:**
  - State IDLE, bit_cnt=0, word_q=0, fix_pending=0.
  - in_ready=1.
  - ser_valid=0, ser_last=0, ser_bit=0, done=0.
  - reg_enable=0, reg_load=0, reg_mode=2'b10.
  - err_count=0, uncorr=0.
- **Reset mid-transfer:** returns to IDLE at once; no done pulse; uncorr and err_count are cleared.
- **Output types:**
  - Combinational from state and inputs: ser_valid, ser_bit, ser_last, in_ready, and all reg_* outputs.
  - Registered: done, err_count, uncorr.
- **Nominal timeline (no faults, ser_ready=1):**
  - Accept edge ends cycle 0; LOAD in cycle 1.
  - Bits are emitted in cycles 2..WIDTH+1.
  - done and in_ready are high in cycle WIDTH+2.
  - Throughput is one word per WIDTH+2 cycles.
- **Correction cost:** each correction adds exactly one cycle. The corrected bit is presented the cycle after the stall.
- **Backpressure:** ser_ready=0 holds the register and bit_cnt; ser_bit stays stable.
- **Fault with ser_ready=0:** counts as a correction cycle, not a plain hold.
- **in_valid outside IDLE:** ignored; no buffering.

## Test plan
- **Nominal transfer:** WIDTH=4, in_data=4'b1011, ser_ready=1.
  - ser_bit=1,1,0,1 in cycles 2-5, with ser_last in cycle 5.
  - done and in_ready in cycle 6; err_count=0.
- **Backpressure:** same word, ser_ready low during the second bit for 3 cycles.
  - Bit 1 is held stable for those 3 cycles with reg_enable=0.
  - Sequence otherwise unchanged; done in cycle 9.
- **Single-bit correction:** force reg_fault=1 for one cycle in SHIFT before bit 2.
  - ser_valid=0 and reg_enable=0 that cycle; err_count=1.
  - All 4 bits still delivered; done delayed by 1 cycle.
- **Uncorrectable error:** reg_fault=1 for two consecutive cycles in SHIFT.
  - uncorr=1 and return to IDLE; no done; err_count=1.
  - clr_err then gives err_count=0 and uncorr=0.
- **Saturation and clear priority:** CNT_W=2, four isolated IDLE faults.
  - err_count=3, not wrapping.
  - clr_err coincident with a fifth fault gives err_count=0.
- **Reset mid-transfer:** assert rst during bit 2.
  - All outputs take reset values asynchronously.
  - After release, a new word transfers correctly.
